// File: rtl/yoda_pkg.sv
// Shared clock-domain constants and helpers for the front-panel UI blocks.
// Default button timings are derived from CLK_HZ.
package yoda_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return ms * (CLK_HZ / 1000);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned DEFAULT_LOCK_CYCLES   = ms_to_cycles(20);
    localparam int unsigned DEFAULT_HOLD_CYCLES   = ms_to_cycles(1000);
    localparam int unsigned DEFAULT_REPEAT_CYCLES = ms_to_cycles(200);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } deb_state_t;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-FF synchroniser, lockout debounce with press/release strobes,
// and an optional hold-to-auto-repeat strobe generator.
module button_debounce_ch
    import yoda_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned LOCK_CYCLES   = DEFAULT_LOCK_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic Clk_100M,
    input  logic Reset,
    input  logic pin,
    output logic debounced,
    output logic press_p,
    output logic release_p,
    output logic repeat_p
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    logic              s1_reg;
    logic              s2_reg;
    deb_state_t        state_reg;
    logic [LOCK_W-1:0] lock_cnt_reg;
    logic              debounced_reg;
    logic              press_reg;
    logic              release_reg;

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            s1_reg        <= 1'b0;
            s2_reg        <= 1'b0;
            state_reg     <= ST_IDLE;
            lock_cnt_reg  <= '0;
            debounced_reg <= 1'b0;
            press_reg     <= 1'b0;
            release_reg   <= 1'b0;
        end else begin
            s1_reg      <= pin ^ ACTIVE_LOW;
            s2_reg      <= s1_reg;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (s2_reg != debounced_reg) begin
                        debounced_reg <= s2_reg;
                        press_reg     <= s2_reg;
                        release_reg   <= ~s2_reg;
                        lock_cnt_reg  <= '0;
                        state_reg     <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Input is ignored for the whole lockout window.
                    if (lock_cnt_reg == LOCK_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign debounced = debounced_reg;
    assign press_p   = press_reg;
    assign release_p = release_reg;

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int HR_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES));
            localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYCLES - 1);
            localparam logic [HR_W-1:0] REP_LAST  = HR_W'(REPEAT_CYCLES - 1);

            logic            accept_edge;
            logic [HR_W-1:0] hr_cnt_reg;
            logic            repeating_reg;
            logic            repeat_reg;

            assign accept_edge = (state_reg == ST_IDLE) && (s2_reg != debounced_reg);

            // One counter serves both the initial hold delay and the repeat period.
            always_ff @(posedge Clk_100M) begin
                if (Reset) begin
                    hr_cnt_reg    <= '0;
                    repeating_reg <= 1'b0;
                    repeat_reg    <= 1'b0;
                end else if (accept_edge || !debounced_reg) begin
                    hr_cnt_reg    <= '0;
                    repeating_reg <= 1'b0;
                    repeat_reg    <= 1'b0;
                end else if (hr_cnt_reg == (repeating_reg ? REP_LAST : HOLD_LAST)) begin
                    hr_cnt_reg    <= '0;
                    repeating_reg <= 1'b1;
                    repeat_reg    <= 1'b1;
                end else begin
                    hr_cnt_reg <= hr_cnt_reg + 1'b1;
                    repeat_reg <= 1'b0;
                end
            end

            assign repeat_p = repeat_reg;
        end else begin : g_no_repeat
            assign repeat_p = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/button_debounce_bank.sv
// N-channel push-button conditioner: one independent debounce channel per pin.
module button_debounce_bank
    import yoda_pkg::*;
#(
    parameter int unsigned     N_CH          = 4,
    parameter bit              ACTIVE_LOW    = 1'b0,
    parameter int unsigned     LOCK_CYCLES   = DEFAULT_LOCK_CYCLES,
    parameter int unsigned     HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int unsigned     REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter logic [N_CH-1:0] REPEAT_MASK   = {N_CH{1'b1}}
) (
    input  logic            Clk_100M,
    input  logic            Reset,
    input  logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] debounced,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] repeat_p
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            button_debounce_ch #(
                .ACTIVE_LOW    (ACTIVE_LOW),
                .LOCK_CYCLES   (LOCK_CYCLES),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES),
                .REPEAT_EN     (REPEAT_MASK[gi])
            ) u_ch (
                .Clk_100M  (Clk_100M),
                .Reset     (Reset),
                .pin       (pressed[gi]),
                .debounced (debounced[gi]),
                .press_p   (press_p[gi]),
                .release_p (release_p[gi]),
                .repeat_p  (repeat_p[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank: an active-high bank driven from a vector table
// and an active-low bank driven by a hand-written sequence, sharing clock and reset.
module tb_button_debounce_bank;

    logic       Clk_100M;
    logic       Reset;
    logic [1:0] pin_a, pin_b;
    logic [1:0] deb_a, prs_a, rel_a, rep_a;
    logic [1:0] deb_b, prs_b, rel_b, rep_b;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int n_prs_a[2], n_rel_a[2], n_rep_a[2];
    int n_prs_b[2], n_rel_b[2], n_rep_b[2];

    button_debounce_bank #(
        .N_CH(2), .ACTIVE_LOW(1'b0), .LOCK_CYCLES(8), .HOLD_CYCLES(20),
        .REPEAT_CYCLES(5), .REPEAT_MASK(2'b01)
    ) dut_a (
        .Clk_100M(Clk_100M), .Reset(Reset), .pressed(pin_a),
        .debounced(deb_a), .press_p(prs_a), .release_p(rel_a), .repeat_p(rep_a)
    );

    button_debounce_bank #(
        .N_CH(2), .ACTIVE_LOW(1'b1), .LOCK_CYCLES(8), .HOLD_CYCLES(20),
        .REPEAT_CYCLES(5), .REPEAT_MASK(2'b01)
    ) dut_b (
        .Clk_100M(Clk_100M), .Reset(Reset), .pressed(pin_b),
        .debounced(deb_b), .press_p(prs_b), .release_p(rel_b), .repeat_p(rep_b)
    );

    initial Clk_100M = 1'b0;
    always #5 Clk_100M = ~Clk_100M;

    always @(posedge Clk_100M) cyc <= cyc + 1;

    // Strobe totals, sampled mid-cycle, catch pulses outside the listed check points.
    always @(negedge Clk_100M) begin
        for (int i = 0; i < 2; i++) begin
            if (prs_a[i]) n_prs_a[i]++;
            if (rel_a[i]) n_rel_a[i]++;
            if (rep_a[i]) n_rep_a[i]++;
            if (prs_b[i]) n_prs_b[i]++;
            if (rel_b[i]) n_rel_b[i]++;
            if (rep_b[i]) n_rep_b[i]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance to 1 time unit after posedge number c.
    task automatic wait_cyc(input int c);
        if (cyc > c) begin
            checks++;
            failures++;
            $display("FAIL schedule cyc=%0d got=late expected=%0d", cyc, c);
        end
        while (cyc < c) begin
            @(posedge Clk_100M);
            #1;
        end
    endtask

    typedef struct {
        int         cyc;
        logic       rst;
        logic [1:0] pin;
        logic [1:0] deb;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] rep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int c, input logic r, input logic [1:0] p,
                                input logic [1:0] d, input logic [1:0] pr,
                                input logic [1:0] rl, input logic [1:0] rp);
        vec_t v;
        v.cyc = c; v.rst = r; v.pin = p; v.deb = d; v.prs = pr; v.rel = rl; v.rep = rp;
        return v;
    endfunction

    // Outputs are checked at cycle cyc, then rst/pin are driven and held until the next entry.
    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            wait_cyc(vecs[i].cyc);
            $display("vec %0d cyc=%0d deb=%b prs=%b rel=%b rep=%b", i, cyc, deb_a, prs_a, rel_a, rep_a);
            chk("a_deb", 32'(deb_a), 32'(vecs[i].deb));
            chk("a_press", 32'(prs_a), 32'(vecs[i].prs));
            chk("a_release", 32'(rel_a), 32'(vecs[i].rel));
            chk("a_repeat", 32'(rep_a), 32'(vecs[i].rep));
            Reset = vecs[i].rst;
            pin_a = vecs[i].pin;
        end
    endtask

    task automatic b_step(input int c, input logic [1:0] d, input logic [1:0] pr, input logic [1:0] rl);
        wait_cyc(c);
        $display("b cyc=%0d deb=%b prs=%b rel=%b", cyc, deb_b, prs_b, rel_b);
        chk("b_deb", 32'(deb_b), 32'(d));
        chk("b_press", 32'(prs_b), 32'(pr));
        chk("b_release", 32'(rel_b), 32'(rl));
    endtask

    // Active-low bank: both pins held low through reset, then a release at the lockout boundary.
    task automatic run_b();
        b_step(2, 2'b00, 2'b00, 2'b00);
        b_step(4, 2'b00, 2'b00, 2'b00);
        b_step(5, 2'b11, 2'b11, 2'b00);
        pin_b = 2'b01 ^ 2'b00 | 2'b01;
        b_step(13, 2'b11, 2'b00, 2'b00);
        b_step(14, 2'b10, 2'b00, 2'b01);
        b_step(15, 2'b10, 2'b00, 2'b00);
        b_step(86, 2'b10, 2'b00, 2'b00);
        b_step(87, 2'b00, 2'b00, 2'b00);
        b_step(90, 2'b00, 2'b00, 2'b00);
        b_step(91, 2'b10, 2'b10, 2'b00);
    endtask

    initial begin
        Reset = 1'b1;
        pin_a = 2'b00;
        pin_b = 2'b00;

        //             cyc  rst  pin    deb    prs    rel    rep
        vecs.push_back(mk(  2, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 10, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 12, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 13, 0, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00));
        vecs.push_back(mk( 14, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 15, 0, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(mk( 16, 0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 17, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 18, 0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 19, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 21, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 22, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 32, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 33, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01));
        vecs.push_back(mk( 34, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 38, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01));
        vecs.push_back(mk( 40, 0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 42, 0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 43, 0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00));
        vecs.push_back(mk( 44, 0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 48, 0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 60, 0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 63, 0, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00));
        vecs.push_back(mk( 72, 0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 75, 0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00));
        vecs.push_back(mk( 83, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01));
        vecs.push_back(mk( 86, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 87, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 88, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 90, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk( 91, 0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00));
        vecs.push_back(mk(110, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(111, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01));
        vecs.push_back(mk(113, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(116, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
        vecs.push_back(mk(117, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

        fork
            run_table();
            run_b();
        join

        wait_cyc(125);
        chk("a_press_cnt0", 32'(n_prs_a[0]), 32'd3);
        chk("a_press_cnt1", 32'(n_prs_a[1]), 32'd1);
        chk("a_release_cnt0", 32'(n_rel_a[0]), 32'd2);
        chk("a_release_cnt1", 32'(n_rel_a[1]), 32'd1);
        chk("a_repeat_cnt0", 32'(n_rep_a[0]), 32'd4);
        chk("a_repeat_cnt1", 32'(n_rep_a[1]), 32'd0);
        chk("b_press_cnt0", 32'(n_prs_b[0]), 32'd1);
        chk("b_press_cnt1", 32'(n_prs_b[1]), 32'd2);
        chk("b_release_cnt0", 32'(n_rel_b[0]), 32'd1);
        chk("b_release_cnt1", 32'(n_rel_b[1]), 32'd0);
        chk("b_repeat_cnt0", 32'(n_rep_b[0]), 32'd0);
        chk("b_repeat_cnt1", 32'(n_rep_b[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
